// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: idle/play/over state, move pacing from the update tick,
// direction latching with reversal rejection, BCD score and apple-driven speed-up.
module snake_game_ctrl #(
    parameter int unsigned INIT_PERIOD  = 8,
    parameter int unsigned MIN_PERIOD   = 2,
    parameter int unsigned SPEED_APPLES = 5
) (
    input  logic       VGA_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       update,
    input  logic       collision,
    input  logic       apple_eaten,
    output logic [1:0] state,
    output logic       move_en,
    output logic [1:0] dir,
    output logic       grow,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic       game_over
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StOver = 2'd2
    } state_e;

    localparam logic [3:0] InitPeriod  = 4'(INIT_PERIOD);
    localparam logic [3:0] MinPeriod   = 4'(MIN_PERIOD);
    localparam logic [3:0] SpeedApples = 4'(SPEED_APPLES);
    localparam logic [1:0] DirRight    = 2'd3;

    state_e     state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [3:0] period_q, period_d;
    logic [3:0] apple_q, apple_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] pend_q, pend_d;
    logic       move_q, move_d;
    logic       grow_q, grow_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    logic       start_s1_q, start_s2_q, start_s3_q, start_p_q;
    // Button bit order matches direction codes: 0=up, 1=down, 2=left, 3=right
    logic [3:0] btn_s1_q, btn_s2_q;
    logic       btn_valid;
    logic [1:0] btn_dir;

    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
            start_p_q  <= 1'b0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
        end else begin
            start_s1_q <= start;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
            start_p_q  <= start_s2_q & ~start_s3_q;
            btn_s1_q   <= {btn_right, btn_left, btn_down, btn_up};
            btn_s2_q   <= btn_s1_q;
        end
    end

    always_comb begin
        btn_valid = |btn_s2_q;
        if (btn_s2_q[0]) begin
            btn_dir = 2'd0;
        end else if (btn_s2_q[1]) begin
            btn_dir = 2'd1;
        end else if (btn_s2_q[2]) begin
            btn_dir = 2'd2;
        end else begin
            btn_dir = 2'd3;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        period_d = period_q;
        apple_d  = apple_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        move_d   = 1'b0;
        grow_d   = 1'b0;

        case (state_q)
            StIdle, StOver: begin
                tick_d = '0;
                if (start_p_q) begin
                    state_d  = StPlay;
                    ones_d   = '0;
                    tens_d   = '0;
                    dir_d    = DirRight;
                    pend_d   = DirRight;
                    period_d = InitPeriod;
                    apple_d  = '0;
                end
            end
            StPlay: begin
                if (collision) begin
                    // Collision pre-empts any move or apple arriving in the same cycle
                    state_d = StOver;
                    tick_d  = '0;
                end else begin
                    // Opposite direction codes differ only in bit 0
                    if (btn_valid && (btn_dir != (dir_q ^ 2'd1))) begin
                        pend_d = btn_dir;
                    end
                    if (update) begin
                        if (tick_q >= period_q - 4'd1) begin
                            tick_d = '0;
                            move_d = 1'b1;
                            dir_d  = pend_q;
                        end else begin
                            tick_d = tick_q + 4'd1;
                        end
                    end
                    if (apple_eaten) begin
                        grow_d = 1'b1;
                        if (!(ones_q == 4'd9 && tens_q == 4'd9)) begin
                            if (ones_q == 4'd9) begin
                                ones_d = '0;
                                tens_d = tens_q + 4'd1;
                            end else begin
                                ones_d = ones_q + 4'd1;
                            end
                        end
                        if (apple_q == SpeedApples - 4'd1) begin
                            apple_d = '0;
                            if (period_q > MinPeriod) begin
                                period_d = period_q - 4'd1;
                            end
                        end else begin
                            apple_d = apple_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            tick_q   <= '0;
            period_q <= InitPeriod;
            apple_q  <= '0;
            dir_q    <= DirRight;
            pend_q   <= DirRight;
            move_q   <= 1'b0;
            grow_q   <= 1'b0;
            ones_q   <= '0;
            tens_q   <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            apple_q  <= apple_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            move_q   <= move_d;
            grow_q   <= grow_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
        end
    end

    assign state      = state_q;
    assign move_en    = move_q;
    assign dir        = dir_q;
    assign grow       = grow_q;
    assign score_ones = ones_q;
    assign score_tens = tens_q;
    assign game_over  = (state_q == StOver);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed phases plus random traffic,
// compared every cycle against a behavioural game model.
module tb_snake_game_ctrl;

    localparam int INIT_P = 8;
    localparam int MIN_P  = 2;
    localparam int SPEED  = 5;

    logic       VGA_clk = 1'b0;
    logic       rst, start, btn_up, btn_down, btn_left, btn_right;
    logic       update, collision, apple_eaten;
    logic [1:0] state, dir;
    logic       move_en, grow, game_over;
    logic [3:0] score_ones, score_tens;

    snake_game_ctrl #(
        .INIT_PERIOD (INIT_P),
        .MIN_PERIOD  (MIN_P),
        .SPEED_APPLES(SPEED)
    ) dut (
        .VGA_clk    (VGA_clk),
        .rst        (rst),
        .start      (start),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .update     (update),
        .collision  (collision),
        .apple_eaten(apple_eaten),
        .state      (state),
        .move_en    (move_en),
        .dir        (dir),
        .grow       (grow),
        .score_ones (score_ones),
        .score_tens (score_tens),
        .game_over  (game_over)
    );

    always #5 VGA_clk = ~VGA_clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Game model: 0=idle 1=play 2=over; score kept as a plain integer
    int   m_state, m_score, m_dir, m_pend, m_period, m_tick, m_apples;
    int   m_move, m_grow;
    bit   sh [0:4];
    logic [3:0] bh [0:2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_dir = 3; m_pend = 3;
        m_period = INIT_P; m_tick = 0; m_apples = 0; m_move = 0; m_grow = 0;
        for (int i = 0; i < 5; i++) sh[i] = 1'b0;
        for (int i = 0; i < 3; i++) bh[i] = 4'h0;
    endtask

    task automatic model_edge();
        bit   sp;
        logic [3:0] b;
        int   old_dir, old_pend, pick;
        for (int i = 4; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = start;
        for (int i = 2; i > 0; i--) bh[i] = bh[i-1];
        bh[0] = {btn_right, btn_left, btn_down, btn_up};
        // start seen 3 edges ago and not 4 edges ago => one-shot start event now
        sp = sh[3] && !sh[4];
        b  = bh[2];
        m_move = 0;
        m_grow = 0;
        if (m_state != 1) begin
            m_tick = 0;
            if (sp) begin
                m_state = 1; m_score = 0; m_dir = 3; m_pend = 3;
                m_period = INIT_P; m_apples = 0;
            end
        end else if (collision) begin
            m_state = 2;
            m_tick  = 0;
        end else begin
            old_dir  = m_dir;
            old_pend = m_pend;
            pick = -1;
            for (int i = 3; i >= 0; i--) if (b[i]) pick = i;
            if (pick >= 0 && pick != (old_dir ^ 1)) m_pend = pick;
            if (update) begin
                if (m_tick >= m_period - 1) begin
                    m_tick = 0;
                    m_move = 1;
                    m_dir  = old_pend;
                end else begin
                    m_tick++;
                end
            end
            if (apple_eaten) begin
                m_grow = 1;
                if (m_score < 99) m_score++;
                m_apples++;
                if (m_apples == SPEED) begin
                    m_apples = 0;
                    if (m_period > MIN_P) m_period--;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".state"},     int'(state),      m_state);
        chk({ph, ".move_en"},   int'(move_en),    m_move);
        chk({ph, ".grow"},      int'(grow),       m_grow);
        chk({ph, ".dir"},       int'(dir),        m_dir);
        chk({ph, ".ones"},      int'(score_ones), m_score % 10);
        chk({ph, ".tens"},      int'(score_tens), m_score / 10);
        chk({ph, ".game_over"}, int'(game_over),  (m_state == 2) ? 1 : 0);
    endtask

    task automatic step(input string ph);
        if (rst) model_reset();
        else model_edge();
        @(posedge VGA_clk);
        #1;
        check_all(ph);
    endtask

    task automatic set_btn(input logic [3:0] v);
        btn_up = v[0]; btn_down = v[1]; btn_left = v[2]; btn_right = v[3];
    endtask

    task automatic press(input logic [3:0] v);
        set_btn(v);
        repeat (3) step("press");
        set_btn(4'h0);
        repeat (3) step("release");
    endtask

    // Issue updates until a move pulse appears; bounded
    task automatic do_move();
        int got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            update = 1'b1;
            step("move_upd");
            update = 1'b0;
            if (move_en) got = 1;
            step("move_gap");
        end
        chk("move_within_bound", got, 1);
    endtask

    initial begin
        int lat, moves, grows;
        rst = 1'b1; start = 1'b0; set_btn(4'h0);
        update = 1'b0; collision = 1'b0; apple_eaten = 1'b0;
        model_reset();
        repeat (2) @(posedge VGA_clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Idle ignores update / collision / apples
        for (int i = 0; i < 20; i++) begin
            update = 1'($urandom_range(0, 1));
            collision = 1'($urandom_range(0, 1));
            apple_eaten = 1'($urandom_range(0, 1));
            step("idle");
        end
        update = 1'b0; collision = 1'b0; apple_eaten = 1'b0;

        // Start held long: exactly one transition, 4 cycles after the press
        start = 1'b1;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            step("start");
            if (state == 2'd1 && lat == 0) lat = c;
        end
        start = 1'b0;
        chk("start_latency", lat, 4);
        chk("start_score", int'(score_ones) + int'(score_tens), 0);

        // One move per 8 updates at the initial period
        moves = 0;
        for (int u = 0; u < 24; u++) begin
            update = 1'b1;
            step("period_upd");
            if (move_en) moves++;
            update = 1'b0;
            for (int g = 0; g < 9; g++) begin
                step("period_gap");
                if (move_en) moves++;
            end
        end
        chk("init_period_moves", moves, 3);

        // Direction handling
        press(4'b0100);
        do_move();
        chk("reverse_rejected", int'(dir), 3);
        press(4'b0001);
        press(4'b0010);
        do_move();
        chk("last_press_wins", int'(dir), 1);
        press(4'b1000);
        do_move();
        chk("back_to_right", int'(dir), 3);
        press(4'b0101);
        do_move();
        chk("up_left_priority", int'(dir), 0);

        // Twelve apples
        grows = 0;
        for (int a = 0; a < 12; a++) begin
            apple_eaten = 1'b1;
            step("apple");
            apple_eaten = 1'b0;
            if (grow) grows++;
            for (int g = 0; g < 2; g++) begin
                step("apple_gap");
                if (grow) grows++;
            end
        end
        chk("score_tens_12", int'(score_tens), 1);
        chk("score_ones_12", int'(score_ones), 2);
        chk("grow_count_12", grows, 12);

        // Random play, no collisions
        for (int i = 0; i < 1500; i++) begin
            update      = ($urandom_range(0, 99) < 30);
            apple_eaten = ($urandom_range(0, 99) < 5);
            btn_up      = ($urandom_range(0, 99) < 5);
            btn_down    = ($urandom_range(0, 99) < 5);
            btn_left    = ($urandom_range(0, 99) < 5);
            btn_right   = ($urandom_range(0, 99) < 5);
            step("random");
        end
        set_btn(4'h0); update = 1'b0; apple_eaten = 1'b0;

        // Score saturation, then play at the floor period
        for (int a = 0; a < 120; a++) begin
            apple_eaten = 1'b1;
            step("sat_apple");
            apple_eaten = 1'b0;
            step("sat_gap");
        end
        chk("sat_tens", int'(score_tens), 9);
        chk("sat_ones", int'(score_ones), 9);
        for (int i = 0; i < 60; i++) begin
            update = ($urandom_range(0, 1) == 1);
            step("floor");
        end
        update = 1'b0;

        // Collision coinciding with apple and with a qualifying update
        collision = 1'b1; apple_eaten = 1'b1; update = 1'b1;
        step("collide");
        collision = 1'b0; apple_eaten = 1'b0; update = 1'b0;
        chk("over_state", int'(state), 2);
        chk("over_flag", int'(game_over), 1);
        chk("over_no_grow", int'(grow), 0);
        chk("over_no_move", int'(move_en), 0);
        moves = 0;
        for (int i = 0; i < 30; i++) begin
            update = 1'($urandom_range(0, 1));
            collision = 1'($urandom_range(0, 1));
            apple_eaten = 1'($urandom_range(0, 1));
            step("over");
            if (move_en) moves++;
        end
        update = 1'b0; collision = 1'b0; apple_eaten = 1'b0;
        chk("over_moves", moves, 0);

        // Restart from OVER
        start = 1'b1;
        repeat (6) step("restart");
        start = 1'b0;
        chk("restart_state", int'(state), 1);
        chk("restart_score", int'(score_tens) * 10 + int'(score_ones), 0);
        moves = 0;
        for (int u = 0; u < 8; u++) begin
            update = 1'b1;
            step("re_upd");
            update = 1'b0;
            if (move_en) moves++;
            if (u == 6) chk("restart_no_early_move", moves, 0);
            step("re_gap");
        end
        chk("restart_period_move", moves, 1);

        // Asynchronous reset mid-play, between edges
        for (int i = 0; i < 40; i++) begin
            update      = ($urandom_range(0, 99) < 40);
            apple_eaten = ($urandom_range(0, 99) < 20);
            btn_up      = ($urandom_range(0, 99) < 10);
            btn_left    = ($urandom_range(0, 99) < 10);
            step("pre_rst");
        end
        set_btn(4'h0); update = 1'b0; apple_eaten = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        step("rst_hold");
        rst = 1'b0;
        repeat (5) step("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
